// File: rtl/modhalf_pipe.sv
// Multi-lane modular halving pipeline: out = in * 2^-k mod q, one halving per stage.
// Optional input range checking with sticky err: define MODHALF_RANGE_CHK_EN.
module modhalf_pipe #(
    parameter int LANES  = 4,
    parameter int W      = 25,
    parameter int STAGES = 8,
    parameter int Q0     = 33292289,
    parameter int Q1     = 16515073
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*W-1:0]           in_data,
    input  logic                         in_mod,
    input  logic [$clog2(STAGES+1)-1:0]  in_k,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*W-1:0]           out_data,
    output logic                         out_mod,
    output logic                         err
);
    localparam int KW = $clog2(STAGES+1);
    localparam logic [W-1:0] HALF0 = W'((Q0 + 1) / 2);
    localparam logic [W-1:0] HALF1 = W'((Q1 + 1) / 2);

    // Odd x: x/2 mod q == (x>>1) + (q+1)/2, which stays below q for x < q.
    function automatic logic [W-1:0] halve(input logic [W-1:0] x, input logic m);
        logic [W-1:0] h;
        h = m ? HALF1 : HALF0;
        return x[0] ? ((x >> 1) + h) : (x >> 1);
    endfunction

    logic          en;
    logic [KW-1:0] kc;

    logic [LANES*W-1:0] pd [STAGES+1];
    logic               pv [STAGES+1];
    logic               pm [STAGES+1];
    logic [KW-1:0]      pk [STAGES];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign kc       = (in_k > KW'(STAGES)) ? KW'(STAGES) : in_k;

    assign pv[0] = in_valid;
    assign pd[0] = in_data;
    assign pm[0] = in_mod;
    assign pk[0] = kc;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [LANES*W-1:0] nd;
        logic [LANES*W-1:0] rd;
        logic               rv;
        logic               rm;

        always_comb begin
            nd = pd[s];
            if (pk[s] > KW'(s)) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    nd[i*W +: W] = halve(pd[s][i*W +: W], pm[s]);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rv <= 1'b0;
                rd <= '0;
                rm <= 1'b0;
            end else if (en) begin
                rv <= pv[s];
                rd <= nd;
                rm <= pm[s];
            end
        end

        assign pv[s+1] = rv;
        assign pd[s+1] = rd;
        assign pm[s+1] = rm;

        // The final stage has no consumer for k, so it is not stored there.
        if (s < STAGES - 1) begin : g_k
            logic [KW-1:0] rk;
            always_ff @(posedge clk) begin
                if (rst)     rk <= '0;
                else if (en) rk <= pk[s];
            end
            assign pk[s+1] = rk;
        end
    end

    assign out_valid = pv[STAGES];
    assign out_data  = pd[STAGES];
    assign out_mod   = pm[STAGES];

`ifdef MODHALF_RANGE_CHK_EN
    localparam logic [W-1:0] QW0 = W'(Q0);
    localparam logic [W-1:0] QW1 = W'(Q1);

    logic bad;
    always_comb begin
        bad = (in_k > KW'(STAGES));
        for (int unsigned i = 0; i < LANES; i++) begin
            if (in_data[i*W +: W] >= (in_mod ? QW1 : QW0)) bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                          err <= 1'b0;
        else if (in_valid && en && bad)   err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
